// File: rtl/core_pkg.sv
// Shared core definitions: MEM_* access encodings, datapath widths and LSU helpers.
package core_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int MEM_CTRL_WIDTH = 4;

    // Bit 3 marks a store; loads and stores are ordered by size within each half.
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_IDLE = 4'h0;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RB   = 4'h1;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RH   = 4'h2;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RW   = 4'h3;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RD   = 4'h4;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RBU  = 4'h5;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RHU  = 4'h6;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_RWU  = 4'h7;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WB   = 4'h8;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WH   = 4'h9;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WW   = 4'hA;
    localparam logic [MEM_CTRL_WIDTH-1:0] MEM_WD   = 4'hB;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} lsu_state_e;

    function automatic logic mem_is_store(input logic [MEM_CTRL_WIDTH-1:0] ctrl);
        return ctrl[3];
    endfunction

    function automatic logic mem_is_signed(input logic [MEM_CTRL_WIDTH-1:0] ctrl);
        return (ctrl == MEM_RB) || (ctrl == MEM_RH) || (ctrl == MEM_RW);
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] mem_size(input logic [MEM_CTRL_WIDTH-1:0] ctrl);
        case (ctrl)
            MEM_RH, MEM_RHU, MEM_WH: return 2'd1;
            MEM_RW, MEM_RWU, MEM_WW: return 2'd2;
            MEM_RD, MEM_WD:          return 2'd3;
            default:                 return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Moves the addressed lanes of a memory read word down to bit 0 and sign/zero-extends them.
module lsu_load_align
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = core_pkg::DATA_WIDTH,
    parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0]     rdata_i,
    input  logic [OFF_WIDTH-1:0]      off_i,
    input  logic [MEM_CTRL_WIDTH-1:0] ctrl_i,
    output logic [DATA_WIDTH-1:0]     data_o
);

    localparam logic [7:0] DW8 = 8'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0]        shifted;
    logic [DATA_WIDTH-1:0]        left;
    logic signed [DATA_WIDTH-1:0] arith;
    logic [7:0]                   keepBits;
    logic [7:0]                   lsh;

    // Push the wanted field to the top, then shift back down arithmetically or logically.
    always_comb begin
        shifted  = rdata_i >> {off_i, 3'b000};
        keepBits = 8'd8 << mem_size(ctrl_i);
        lsh      = (keepBits >= DW8) ? 8'd0 : (DW8 - keepBits);
        left     = shifted << lsh;
        arith    = $signed(left) >>> lsh;
        data_o   = mem_is_signed(ctrl_i) ? $unsigned(arith) : (left >> lsh);
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the MEM stage and the data-memory port.
module load_store_unit
    import core_pkg::*;
#(
    parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH     = core_pkg::ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [MEM_CTRL_WIDTH-1:0] req_ctrl_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      m_req_o,
    output logic                      m_we_o,
    output logic [ADDR_WIDTH-1:0]     m_addr_o,
    output logic [DATA_WIDTH/8-1:0]   m_be_o,
    output logic [DATA_WIDTH-1:0]     m_wdata_o,
    input  logic                      m_gnt_i,
    input  logic                      m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     m_rdata_i
);

    localparam int BE_WIDTH          = DATA_WIDTH / 8;
    localparam int ADDR_OFFSET_WIDTH = $clog2(BE_WIDTH);
    localparam int WDOG_WIDTH        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST =
        (TIMEOUT_CYCLES > 0) ? WDOG_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    lsu_state_e                state_q, state_d;
    logic [MEM_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [WDOG_WIDTH-1:0]     wdog_q, wdog_d;

    logic [1:0]                   reqSize;
    logic [ADDR_OFFSET_WIDTH-1:0] reqOff;
    logic [ADDR_OFFSET_WIDTH-1:0] alignMask;
    logic                         reqBad;
    logic                         wdogExpired;
    logic [1:0]                   sizeQ;
    logic [15:0]                  beWide;
    logic [DATA_WIDTH-1:0]        laneData;
    logic [DATA_WIDTH-1:0]        loadData;
    logic                         inReq;

    lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_WIDTH  (ADDR_OFFSET_WIDTH)
    ) u_load_align (
        .rdata_i (m_rdata_i),
        .off_i   (addr_q[ADDR_OFFSET_WIDTH-1:0]),
        .ctrl_i  (ctrl_q),
        .data_o  (loadData)
    );

    // Requests that are misaligned or not available on this XLEN never reach memory.
    always_comb begin
        reqSize   = mem_size(req_ctrl_i);
        reqOff    = req_addr_i[ADDR_OFFSET_WIDTH-1:0];
        alignMask = ADDR_OFFSET_WIDTH'((4'd1 << reqSize) - 4'd1);
        reqBad    = ((reqOff & alignMask) != '0)
                 || (req_ctrl_i > MEM_WD)
                 || ((DATA_WIDTH == 32) && ((req_ctrl_i == MEM_RWU) ||
                                            (req_ctrl_i == MEM_RD)  ||
                                            (req_ctrl_i == MEM_WD)));
    end

    assign wdogExpired = (TIMEOUT_CYCLES != 0) && (wdog_q >= WDOG_LAST);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        wdog_d     = wdog_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    ctrl_d     = req_ctrl_i;
                    addr_d     = req_addr_i;
                    wdata_d    = req_wdata_i;
                    wdog_d     = '0;
                    rsp_data_d = '0;
                    rsp_err_d  = reqBad;
                    state_d    = (reqBad || (req_ctrl_i == MEM_IDLE)) ? RSP : REQ;
                end
            end
            REQ: begin
                wdog_d = wdog_q + WDOG_WIDTH'(1);
                if (m_gnt_i) begin
                    state_d = WAIT;
                end else if (wdogExpired) begin
                    state_d    = RSP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end
            WAIT: begin
                wdog_d = wdog_q + WDOG_WIDTH'(1);
                if (m_rvalid_i) begin
                    state_d    = RSP;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = mem_is_store(ctrl_q) ? '0 : loadData;
                end else if (wdogExpired) begin
                    state_d    = RSP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            wdog_q     <= wdog_d;
        end
    end

    // Byte enables and lane-replicated store data, derived from the held capture registers.
    always_comb begin
        sizeQ  = mem_size(ctrl_q);
        beWide = ((16'd1 << (4'd1 << sizeQ)) - 16'd1) << addr_q[ADDR_OFFSET_WIDTH-1:0];
        case (sizeQ)
            2'd0:    laneData = {BE_WIDTH{wdata_q[7:0]}};
            2'd1:    laneData = {(BE_WIDTH/2){wdata_q[15:0]}};
            2'd2:    laneData = {(BE_WIDTH/4){wdata_q[31:0]}};
            default: laneData = wdata_q;
        endcase
    end

    assign inReq       = (state_q == REQ);
    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_data_o  = (state_q == RSP) ? rsp_data_q : '0;
    assign rsp_err_o   = (state_q == RSP) && rsp_err_q;
    assign m_req_o     = inReq;
    assign m_we_o      = inReq && mem_is_store(ctrl_q);
    assign m_addr_o    = inReq ? {addr_q[ADDR_WIDTH-1:ADDR_OFFSET_WIDTH], {ADDR_OFFSET_WIDTH{1'b0}}} : '0;
    assign m_be_o      = inReq ? beWide[BE_WIDTH-1:0] : '0;
    assign m_wdata_o   = inReq ? laneData : '0;

endmodule
